mode_key_ctrl: RTL and testbench

//  Front-panel controller for the multi-mode clock: debounces KEY[3:0] and runs the mode FSM (clock / time-set / stopwatch / alarm).

---
 rtl/mkc_pkg.sv | 44 ++++
 rtl/key_debounce.sv | 60 ++++++
 rtl/mode_key_ctrl.sv | 109 ++++++++++
 tb/tb_mode_key_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mkc_pkg.sv
// Shared state codes, display codes and field one-hots for the mode/key controller,
// the clock top level and the displayer.
package mkc_pkg;

    typedef enum logic [3:0] {
        CLOCK     = 4'd0,
        TSET      = 4'd1,
        TSET_H    = 4'd2,
        TSET_M    = 4'd3,
        TSET_S    = 4'd4,
        STOPWATCH = 4'd5,
        ALARM     = 4'd6,
        AL_H      = 4'd7,
        AL_M      = 4'd8,
        AL_S      = 4'd9
    } mkc_state_e;

    localparam logic [1:0] DISP_CLOCK = 2'd0;
    localparam logic [1:0] DISP_SW    = 2'd1;
    localparam logic [1:0] DISP_ALARM = 2'd2;

    localparam logic [2:0] FIELD_NONE = 3'b000;
    localparam logic [2:0] FIELD_H    = 3'b100;
    localparam logic [2:0] FIELD_M    = 3'b010;
    localparam logic [2:0] FIELD_S    = 3'b001;

    function automatic logic [2:0] field_of(input mkc_state_e s);
        case (s)
            TSET_H, AL_H: field_of = FIELD_H;
            TSET_M, AL_M: field_of = FIELD_M;
            TSET_S, AL_S: field_of = FIELD_S;
            default:      field_of = FIELD_NONE;
        endcase
    endfunction

    function automatic logic [1:0] disp_of(input mkc_state_e s);
        case (s)
            STOPWATCH:              disp_of = DISP_SW;
            ALARM, AL_H, AL_M, AL_S: disp_of = DISP_ALARM;
            default:                disp_of = DISP_CLOCK;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One-key synchronizer + debouncer producing a stable level and a one-cycle press
// event, with optional hold-to-repeat.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int REPEAT_DLY   = 25_000_000,
    parameter int REPEAT_PER   = 10_000_000,
    parameter bit REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_n,
    input  logic rep_clr,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int RPT_W = $clog2(REPEAT_DLY + 1);

    logic             sync_p0, sync_p1;
    logic [CNT_W-1:0] deb_cnt;
    logic [RPT_W-1:0] rep_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            deb_cnt <= '0;
            rep_cnt <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
            press   <= 1'b0;

            if (sync_p1 == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                deb_cnt <= '0;
                level   <= sync_p1;
                press   <= ~sync_p1;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            // Counter sits at 0 on the press edge, so the first repeat lands REPEAT_DLY later;
            // reloading to DLY-PER makes later repeats REPEAT_PER apart.
            if (!REPEAT_EN || level || rep_clr) begin
                rep_cnt <= '0;
            end else if (rep_cnt == RPT_W'(REPEAT_DLY - 1)) begin
                rep_cnt <= RPT_W'(REPEAT_DLY - REPEAT_PER);
                press   <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mode_key_ctrl.sv
// Front-panel mode FSM: turns debounced key events into registered mode, field
// inc/dec pulses, stopwatch start level and alarm dismiss.
module mode_key_ctrl
    import mkc_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int REPEAT_DLY   = 25_000_000,
    parameter int REPEAT_PER   = 10_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] key_n,
    input  logic       sw_run,
    output logic [3:0] mode,
    output logic [1:0] disp_sel,
    output logic [2:0] edit_field,
    output logic [2:0] clock_inc,
    output logic [2:0] clock_dec,
    output logic [2:0] alarm_inc,
    output logic [2:0] alarm_dec,
    output logic       sw_start,
    output logic       alarm_dismiss
);

    logic [3:0] unused_key_lvl;
    logic [3:0] key_evt;
    mkc_state_e state, state_nx;
    logic       mode_chg;
    logic       in_tset, in_al, fld_evt;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .REPEAT_DLY   (REPEAT_DLY),
            .REPEAT_PER   (REPEAT_PER),
            .REPEAT_EN    (k >= 2)
        ) u_deb (
            .clk     (clk),
            .rstn    (rstn),
            .key_n   (key_n[k]),
            .rep_clr (mode_chg),
            .level   (unused_key_lvl[k]),
            .press   (key_evt[k])
        );
    end

    // KEY0 (mode) is tested first everywhere, so it wins over KEY1 in the same cycle.
    always_comb begin
        state_nx = state;
        case (state)
            CLOCK:                if (key_evt[0]) state_nx = TSET;
            TSET, TSET_S:         if (key_evt[0]) state_nx = STOPWATCH;
                                  else if (key_evt[1]) state_nx = TSET_H;
            TSET_H:               if (key_evt[0]) state_nx = STOPWATCH;
                                  else if (key_evt[1]) state_nx = TSET_M;
            TSET_M:               if (key_evt[0]) state_nx = STOPWATCH;
                                  else if (key_evt[1]) state_nx = TSET_S;
            STOPWATCH:            if (key_evt[0]) state_nx = ALARM;
            ALARM, AL_S:          if (key_evt[0]) state_nx = CLOCK;
                                  else if (key_evt[1]) state_nx = AL_H;
            AL_H:                 if (key_evt[0]) state_nx = CLOCK;
                                  else if (key_evt[1]) state_nx = AL_M;
            AL_M:                 if (key_evt[0]) state_nx = CLOCK;
                                  else if (key_evt[1]) state_nx = AL_S;
            default:              state_nx = CLOCK;
        endcase
    end

    assign mode_chg = (state_nx != state);
    assign in_tset  = (state == TSET_H) || (state == TSET_M) || (state == TSET_S);
    assign in_al    = (state == AL_H) || (state == AL_M) || (state == AL_S);
    assign fld_evt  = !key_evt[0] && (key_evt[2] || key_evt[3]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= CLOCK;
            clock_inc     <= '0;
            clock_dec     <= '0;
            alarm_inc     <= '0;
            alarm_dec     <= '0;
            sw_start      <= 1'b0;
            alarm_dismiss <= 1'b0;
        end else begin
            state         <= state_nx;
            clock_inc     <= '0;
            clock_dec     <= '0;
            alarm_inc     <= '0;
            alarm_dec     <= '0;
            alarm_dismiss <= key_evt[1] && !key_evt[0]
                             && ((state == CLOCK) || (state == STOPWATCH));

            // inc beats dec; only one bus can be loaded per cycle.
            if (fld_evt && in_tset) begin
                if (key_evt[2]) clock_inc <= field_of(state);
                else            clock_dec <= field_of(state);
            end else if (fld_evt && in_al) begin
                if (key_evt[2]) alarm_inc <= field_of(state);
                else            alarm_dec <= field_of(state);
            end

            if (state == STOPWATCH) sw_start <= sw_run;
        end
    end

    assign mode       = state;
    assign disp_sel   = disp_of(state);
    assign edit_field = field_of(state);

endmodule

// File: tb/tb_mode_key_ctrl.sv
// Directed bench for mode_key_ctrl with short debounce/repeat timing.
module tb_mode_key_ctrl;
    import mkc_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] key_n;
    logic       sw_run;
    logic [3:0] mode;
    logic [1:0] disp_sel;
    logic [2:0] edit_field;
    logic [2:0] clock_inc, clock_dec, alarm_inc, alarm_dec;
    logic       sw_start, alarm_dismiss;

    int vec  = 0;
    int miss = 0;

    mode_key_ctrl #(
        .DEBOUNCE_CYC (4),
        .REPEAT_DLY   (20),
        .REPEAT_PER   (5)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .key_n         (key_n),
        .sw_run        (sw_run),
        .mode          (mode),
        .disp_sel      (disp_sel),
        .edit_field    (edit_field),
        .clock_inc     (clock_inc),
        .clock_dec     (clock_dec),
        .alarm_inc     (alarm_inc),
        .alarm_dec     (alarm_dec),
        .sw_start      (sw_start),
        .alarm_dismiss (alarm_dismiss)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Press at a negedge; event-driven outputs are visible 7 negedges later.
    task automatic press_keys(input logic [3:0] m);
        key_n = key_n & ~m;
        tick(7);
    endtask

    task automatic release_keys(input logic [3:0] m);
        key_n = key_n | m;
        tick(8);
    endtask

    logic [63:0] seen_mask;
    int          n_inc, n_other;

    initial begin
        rstn   = 1'b0;
        key_n  = 4'hF;
        sw_run = 1'b0;
        tick(3);
        chk("rst_mode", 64'(mode), 64'(CLOCK));
        chk("rst_disp", 64'(disp_sel), 64'd0);
        chk("rst_field", 64'(edit_field), 64'd0);
        chk("rst_pulses", 64'({clock_inc, clock_dec, alarm_inc, alarm_dec, alarm_dismiss}), 64'd0);
        chk("rst_sw_start", 64'(sw_start), 64'd0);
        rstn = 1'b1;
        tick(2);

        // 3-cycle glitch must be filtered
        key_n[0] = 1'b0;
        tick(3);
        key_n[0] = 1'b1;
        tick(10);
        chk("glitch_mode", 64'(mode), 64'(CLOCK));

        // held KEY0: TSET exactly 7 cycles after the fall
        key_n[0] = 1'b0;
        tick(6);
        chk("tset_lat6", 64'(mode), 64'(CLOCK));
        tick(1);
        chk("tset_lat7", 64'(mode), 64'(TSET));
        chk("tset_field", 64'(edit_field), 64'd0);
        release_keys(4'b0001);

        press_keys(4'b0010);
        chk("tset_h_mode", 64'(mode), 64'(TSET_H));
        chk("tset_h_field", 64'(edit_field), 64'b100);
        release_keys(4'b0010);

        press_keys(4'b0100);
        chk("inc_h", 64'(clock_inc), 64'b100);
        chk("inc_h_others", 64'({clock_dec, alarm_inc, alarm_dec}), 64'd0);
        tick(1);
        chk("inc_h_1cyc", 64'(clock_inc), 64'd0);
        release_keys(4'b0100);

        press_keys(4'b0010);
        chk("tset_m_mode", 64'(mode), 64'(TSET_M));
        chk("tset_m_field", 64'(edit_field), 64'b010);
        release_keys(4'b0010);

        // KEY2 held: pulses at 7, 27, 32, 37, 42 cycles after the fall
        seen_mask = '0;
        n_inc = 0;
        n_other = 0;
        key_n[2] = 1'b0;
        for (int i = 1; i <= 55; i++) begin
            @(negedge clk);
            if (clock_inc == 3'b010) begin
                n_inc++;
                seen_mask[i] = 1'b1;
            end else if (clock_inc != 3'b000) begin
                n_other++;
            end
            if ((clock_dec | alarm_inc | alarm_dec) != 3'b000) n_other++;
            if (i == 38) key_n[2] = 1'b1;
        end
        chk("repeat_count", 64'(n_inc), 64'd5);
        chk("repeat_times", seen_mask,
            (64'd1 << 7) | (64'd1 << 27) | (64'd1 << 32) | (64'd1 << 37) | (64'd1 << 42));
        chk("repeat_other", 64'(n_other), 64'd0);
        chk("repeat_mode", 64'(mode), 64'(TSET_M));

        press_keys(4'b0010);
        chk("tset_s_mode", 64'(mode), 64'(TSET_S));
        release_keys(4'b0010);
        press_keys(4'b0010);
        chk("tset_wrap_h", 64'(mode), 64'(TSET_H));
        release_keys(4'b0010);

        // KEY0 + KEY1 together: KEY0 wins
        press_keys(4'b0011);
        chk("k0k1_mode", 64'(mode), 64'(STOPWATCH));
        chk("k0k1_disp", 64'(disp_sel), 64'd1);
        chk("k0k1_dismiss", 64'(alarm_dismiss), 64'd0);
        release_keys(4'b0011);

        sw_run = 1'b1;
        tick(2);
        chk("sw_start_on", 64'(sw_start), 64'd1);
        press_keys(4'b0001);
        chk("alarm_mode", 64'(mode), 64'(ALARM));
        chk("alarm_disp", 64'(disp_sel), 64'd2);
        release_keys(4'b0001);
        sw_run = 1'b0;
        tick(3);
        chk("sw_start_hold", 64'(sw_start), 64'd1);

        press_keys(4'b0010);
        release_keys(4'b0010);
        press_keys(4'b0010);
        release_keys(4'b0010);
        press_keys(4'b0010);
        chk("al_s_mode", 64'(mode), 64'(AL_S));
        release_keys(4'b0010);

        // KEY2 and KEY3 stable in the same cycle: inc only
        press_keys(4'b1100);
        chk("al_inc_s", 64'(alarm_inc), 64'b001);
        chk("al_inc_others", 64'({alarm_dec, clock_inc, clock_dec}), 64'd0);
        release_keys(4'b1100);

        press_keys(4'b1000);
        chk("al_dec_s", 64'(alarm_dec), 64'b001);
        release_keys(4'b1000);

        press_keys(4'b0010);
        chk("al_wrap_h", 64'(mode), 64'(AL_H));
        release_keys(4'b0010);
        press_keys(4'b0010);
        chk("al_m_mode", 64'(mode), 64'(AL_M));
        release_keys(4'b0010);

        // reset pulse while in AL_M
        rstn = 1'b0;
        tick(1);
        chk("rst2_mode", 64'(mode), 64'(CLOCK));
        chk("rst2_outs", 64'({disp_sel, edit_field, sw_start, alarm_dismiss}), 64'd0);
        rstn = 1'b1;
        tick(2);

        // KEY1 in CLOCK dismisses the alarm for one cycle
        press_keys(4'b0010);
        chk("dismiss_on", 64'(alarm_dismiss), 64'd1);
        chk("dismiss_mode", 64'(mode), 64'(CLOCK));
        tick(1);
        chk("dismiss_1cyc", 64'(alarm_dismiss), 64'd0);
        release_keys(4'b0010);

        // reset mid-debounce restarts the full debounce
        key_n[0] = 1'b0;
        tick(3);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        tick(6);
        chk("rst_deb_lat6", 64'(mode), 64'(CLOCK));
        tick(1);
        chk("rst_deb_lat7", 64'(mode), 64'(TSET));
        release_keys(4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
